// File: rtl/b_bus_pkg.sv
// Shared B-bus definitions: mux modes, source codes, FSM states, code legality.
// Pure declarations, no timing of its own.
// No flow control here; consumers apply it.
package b_bus_pkg;

    localparam int SRC_W = 5;

    // Registered source-mux operating modes
    localparam logic [1:0] MUX_HOLD = 2'd0;
    localparam logic [1:0] MUX_RG2  = 2'd1;
    localparam logic [1:0] MUX_DIR  = 2'd2;

    // Source codes understood by the B-bus mux
    localparam logic [SRC_W-1:0] SRC_R1   = 5'd1;
    localparam logic [SRC_W-1:0] SRC_R2   = 5'd2;
    localparam logic [SRC_W-1:0] SRC_R3   = 5'd3;
    localparam logic [SRC_W-1:0] SRC_R4   = 5'd4;
    localparam logic [SRC_W-1:0] SRC_R5   = 5'd5;
    localparam logic [SRC_W-1:0] SRC_R6   = 5'd6;
    localparam logic [SRC_W-1:0] SRC_R7   = 5'd7;
    localparam logic [SRC_W-1:0] SRC_R8   = 5'd8;
    localparam logic [SRC_W-1:0] SRC_R9   = 5'd9;
    localparam logic [SRC_W-1:0] SRC_R10  = 5'd10;
    localparam logic [SRC_W-1:0] SRC_R11  = 5'd11;
    localparam logic [SRC_W-1:0] SRC_R12  = 5'd12;
    localparam logic [SRC_W-1:0] SRC_R13  = 5'd13;
    localparam logic [SRC_W-1:0] SRC_R14  = 5'd14;
    localparam logic [SRC_W-1:0] SRC_TOTR = 5'd15;
    localparam logic [SRC_W-1:0] SRC_I    = 5'd23;

    // Scheduler FSM states
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SELECT  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    // Only the register file (1..15) and the I source (23) may drive the bus
    function automatic logic code_legal(input logic [SRC_W-1:0] code);
        return ((code != '0) && (code <= SRC_TOTR)) || (code == SRC_I);
    endfunction

endpackage

// File: rtl/b_bus_scheduler_rr_pick.sv
// Round-robin picker: first asserted request at or above the pointer, with wrap.
// Purely combinational, zero latency.
// No backpressure; the caller decides whether to act on the winner.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    // Scan ptr, ptr+1, ... with wrap; the first hit wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!vld_o && req_i[IW'((int'(ptr_i) + k) % N)]) begin
                vld_o = 1'b1;
                gnt_o[IW'((int'(ptr_i) + k) % N)] = 1'b1;
                idx_o = IW'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/b_bus_scheduler.sv
// Arbitrates the registered B-bus source mux among NREQ requesters (round-robin + lock).
// req sampled at edge t -> grant in cycle t+1 -> valid in cycle t+2; locked bursts every 2 cycles.
// Requesters hold req until their valid pulse; illegal codes are rejected with an err pulse.
module b_bus_scheduler
    import b_bus_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int SEL_W = 5
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*SEL_W-1:0] req_code,
    input  logic [SEL_W-1:0]      rg2_code,
    input  logic [NREQ-1:0]       lock,
    output logic [1:0]            MUX2S,
    output logic [SEL_W-1:0]      MUX2D_out,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       valid,
    output logic [NREQ-1:0]       err,
    output logic                  busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [1:0]       mux2s_q, mux2s_d;
    logic [SEL_W-1:0] mux2d_q, mux2d_d;
    logic [NREQ-1:0]  err_q, err_d;

    logic [NREQ-1:0]  pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_vld;

    logic [NREQ-1:0]  owner_oh;
    logic [IW-1:0]    sel_idx;
    logic [SEL_W-1:0] sel_code;
    logic             sel_legal;
    logic             keep_bus;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    assign owner_oh = NREQ'(1) << owner_q;
    assign keep_bus = |(lock & req & owner_oh);

    // Next pointer position after idx, wrapping at NREQ
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
        if (int'(idx) == NREQ - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Candidate under legality check: the current owner on a lock re-check, else the RR winner
    always_comb begin
        sel_idx  = (state_q == CAPTURE) ? owner_q : pick_idx;
        sel_code = rg2_code;
        for (int i = 1; i < NREQ; i++) begin
            if (sel_idx == IW'(i)) begin
                sel_code = req_code[i*SEL_W +: SEL_W];
            end
        end
        sel_legal = code_legal(SRC_W'(sel_code));
    end

    // FSM next state, owner/pointer update and mux select loading
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        mux2s_d = mux2s_q;
        mux2d_d = mux2d_q;
        err_d   = '0;
        case (state_q)
            IDLE: begin
                mux2s_d = MUX_HOLD;
                if (pick_vld) begin
                    if (sel_legal) begin
                        state_d = SELECT;
                        owner_d = pick_idx;
                        if (pick_idx == '0) begin
                            mux2s_d = MUX_RG2;
                            mux2d_d = '0;
                        end else begin
                            mux2s_d = MUX_DIR;
                            mux2d_d = sel_code;
                        end
                    end else begin
                        // Skip past a stuck illegal requester so others are not starved
                        err_d = pick_gnt;
                        ptr_d = wrap_inc(pick_idx);
                    end
                end
            end
            SELECT: begin
                // Mux samples the select at this cycle's closing edge, then holds
                state_d = CAPTURE;
                mux2s_d = MUX_HOLD;
            end
            CAPTURE: begin
                mux2s_d = MUX_HOLD;
                if (keep_bus && sel_legal) begin
                    state_d = SELECT;
                    if (owner_q == '0) begin
                        mux2s_d = MUX_RG2;
                        mux2d_d = '0;
                    end else begin
                        mux2s_d = MUX_DIR;
                        mux2d_d = sel_code;
                    end
                end else begin
                    if (keep_bus) begin
                        err_d = owner_oh;
                    end
                    state_d = IDLE;
                    ptr_d   = wrap_inc(owner_q);
                end
            end
            default: begin
                state_d = IDLE;
                mux2s_d = MUX_HOLD;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            mux2s_q <= MUX_HOLD;
            mux2d_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            mux2s_q <= mux2s_d;
            mux2d_q <= mux2d_d;
            err_q   <= err_d;
        end
    end

    assign MUX2S     = mux2s_q;
    assign MUX2D_out = mux2d_q;
    assign grant     = (state_q == SELECT)  ? owner_oh : '0;
    assign valid     = (state_q == CAPTURE) ? owner_oh : '0;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_b_bus_scheduler.sv
// Directed bench for b_bus_scheduler with a transfer scoreboard and a B-bus mux model.
// Expected transfers are queued when stimulus is applied and retired on each valid pulse.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
module tb_b_bus_scheduler;

    localparam int NREQ  = 3;
    localparam int SEL_W = 5;

    logic                  Clock;
    logic                  Resetn;
    logic [NREQ-1:0]       req;
    logic [NREQ*SEL_W-1:0] req_code;
    logic [SEL_W-1:0]      rg2_code;
    logic [NREQ-1:0]       lock;
    logic [1:0]            MUX2S;
    logic [SEL_W-1:0]      MUX2D_out;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       valid;
    logic [NREQ-1:0]       err;
    logic                  busy;

    logic [SEL_W-1:0]      bus_q;

    typedef struct {
        int idx;
        int code;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    b_bus_scheduler #(
        .NREQ  (NREQ),
        .SEL_W (SEL_W)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .req       (req),
        .req_code  (req_code),
        .rg2_code  (rg2_code),
        .lock      (lock),
        .MUX2S     (MUX2S),
        .MUX2D_out (MUX2D_out),
        .grant     (grant),
        .valid     (valid),
        .err       (err),
        .busy      (busy)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Model of the registered B-bus mux: the bus carries the selected source code
    always @(posedge Clock) begin
        if (!Resetn) begin
            bus_q <= '0;
        end else if (MUX2S == 2'd1) begin
            bus_q <= rg2_code;
        end else if (MUX2S == 2'd2) begin
            bus_q <= MUX2D_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, then check invariants and retire any transfer
    task automatic cyc();
        exp_t e;
        @(negedge Clock);
        chk("grant_valid_excl", 32'(grant & valid), 0);
        if (valid != '0) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_valid", 32'(valid), 0);
            end else begin
                e = sb.pop_front();
                chk("sb_valid", 32'(valid), 32'(1 << e.idx));
                chk("sb_bus", 32'(bus_q), 32'(e.code));
            end
        end
    endtask

    task automatic wait_grant(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (grant != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s timeout observed=no_grant expected=grant", tag);
        end
    endtask

    task automatic push(input int idx, input int code);
        exp_t e;
        e.idx  = idx;
        e.code = code;
        sb.push_back(e);
    endtask

    initial begin
        Resetn   = 1'b0;
        req      = 3'b111;
        lock     = 3'b000;
        rg2_code = 5'd7;
        req_code = '0;
        req_code[1*SEL_W +: SEL_W] = 5'd5;
        req_code[2*SEL_W +: SEL_W] = 5'd3;

        // Reset held for two edges with all requests pending
        cyc();
        cyc();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_mux2s", 32'(MUX2S), 0);
        chk("rst_mux2d", 32'(MUX2D_out), 0);
        chk("rst_busy", 32'(busy), 0);

        // Round-robin with all three requesting: order 0,1,2,0
        push(0, 7);
        push(1, 5);
        push(2, 3);
        push(0, 7);
        Resetn = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wait_grant("rr_wait");
            chk("rr_grant", 32'(grant), 32'(1 << (t % 3)));
            chk("rr_mux2s", 32'(MUX2S), ((t % 3) == 0) ? 1 : 2);
            chk("rr_busy", 32'(busy), 1);
            if (t == 3) req = 3'b000;
        end
        cyc();
        cyc();
        chk("rr_idle", 32'(busy), 0);

        // Illegal code on requester 1 while requester 2 (code 3) also asks
        req_code[1*SEL_W +: SEL_W] = 5'd20;
        req = 3'b110;
        push(2, 3);
        cyc();
        chk("ill_err", 32'(err), 32'b010);
        chk("ill_grant", 32'(grant), 0);
        chk("ill_mux2s", 32'(MUX2S), 0);
        req = 3'b100;
        cyc();
        chk("ill_err_clear", 32'(err), 0);
        chk("ill_next_grant", 32'(grant), 32'b100);
        chk("ill_next_mux2s", 32'(MUX2S), 2);
        chk("ill_next_mux2d", 32'(MUX2D_out), 3);
        cyc();
        req = 3'b000;
        cyc();
        chk("ill_idle", 32'(busy), 0);

        // Single direct read of R5 by requester 1
        req_code[1*SEL_W +: SEL_W] = 5'd5;
        req = 3'b010;
        push(1, 5);
        cyc();
        chk("dir_grant", 32'(grant), 32'b010);
        chk("dir_mux2s", 32'(MUX2S), 2);
        chk("dir_mux2d", 32'(MUX2D_out), 5);
        cyc();
        chk("dir_valid", 32'(valid), 32'b010);
        chk("dir_hold", 32'(MUX2S), 0);
        req = 3'b000;
        cyc();
        chk("dir_idle", 32'(busy), 0);

        // Locked burst of four I-source reads by requester 2 while requester 1 waits
        req_code[2*SEL_W +: SEL_W] = 5'd23;
        req  = 3'b110;
        lock = 3'b100;
        for (int b = 0; b < 4; b++) push(2, 23);
        push(1, 5);
        for (int b = 0; b < 4; b++) begin
            cyc();
            chk("lock_grant", 32'(grant), 32'b100);
            cyc();
            chk("lock_valid", 32'(valid), 32'b100);
        end
        lock = 3'b000;
        req  = 3'b010;
        cyc();
        chk("lock_release_gap", 32'(grant), 0);
        cyc();
        chk("lock_then_req1", 32'(grant), 32'b010);
        cyc();
        req = 3'b000;
        cyc();

        // Reset asserted during SELECT aborts the transfer
        req = 3'b010;
        cyc();
        chk("rsel_grant", 32'(grant), 32'b010);
        Resetn = 1'b0;
        cyc();
        chk("rsel_valid", 32'(valid), 0);
        chk("rsel_grant0", 32'(grant), 0);
        chk("rsel_mux2s", 32'(MUX2S), 0);
        chk("rsel_mux2d", 32'(MUX2D_out), 0);
        chk("rsel_busy", 32'(busy), 0);
        Resetn = 1'b1;
        req    = 3'b000;
        cyc();
        cyc();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
